// File: rtl/xilinx_serial_host_pkg.sv
`default_nettype none
// ============================================================================
// Module  : xilinx_serial_host_pkg
// Brief   : BCH sizing helpers, MISR constants and host FSM state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package xilinx_serial_host_pkg;

    typedef struct packed {
        int unsigned m;
        int unsigned t;
        int unsigned data_bits;
    } bch_params_t;

    // Smallest field degree m with 2^m-1 >= data_bits + m*t.
    function automatic bch_params_t bch_params(input int unsigned data_bits,
                                               input int unsigned t);
        bch_params_t p;
        bit          found;
        p.m         = 16;
        p.t         = t;
        p.data_bits = data_bits;
        found       = 1'b0;
        for (int unsigned m = 2; m <= 16; m++) begin
            if (!found && (((32'd1 << m) - 32'd1) >= (data_bits + m * t))) begin
                p.m   = m;
                found = 1'b1;
            end
        end
        return p;
    endfunction

    function automatic int unsigned BCH_M(input bch_params_t p);
        return p.m;
    endfunction

    localparam int unsigned          MISR_WIDTH = 32;
    localparam logic [MISR_WIDTH-1:0] MISR_POLY = 32'h04C11DB7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } host_state_e;

endpackage
`default_nettype wire

// File: rtl/xilinx_serial_misr.sv
`default_nettype none
// ============================================================================
// Module  : xilinx_serial_misr
// Brief   : Two-flop synchronizer on the harness output pin feeding a MISR.
// Revision: 1.0 - initial release
// ============================================================================
module xilinx_serial_misr
    import xilinx_serial_host_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ser_in,
    input  logic                  sig_clear,
    output logic [MISR_WIDTH-1:0] sig
);

    logic [1:0]            sync_q;
    logic [MISR_WIDTH-1:0] sig_q;
    logic [MISR_WIDTH-1:0] sig_d;

    always_comb begin
        sig_d = {sig_q[MISR_WIDTH-2:0], 1'b0}
              ^ (sig_q[MISR_WIDTH-1] ? MISR_POLY : '0)
              ^ {{(MISR_WIDTH-1){1'b0}}, sync_q[1]};
        if (sig_clear) begin
            sig_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            sig_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], ser_in};
            sig_q  <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule
`default_nettype wire

// File: rtl/xilinx_serial_host.sv
`default_nettype none
// ============================================================================
// Module  : xilinx_serial_host
// Brief   : Serializes sigma words into framed bit streams and compacts the
//           harness response into a MISR signature.
// Revision: 1.0 - initial release
// ============================================================================
module xilinx_serial_host
    import xilinx_serial_host_pkg::*;
#(
    parameter  int unsigned T         = 2,
    parameter  int unsigned DATA_BITS = 5,
    parameter  int unsigned GAP       = 4,
    localparam bch_params_t P         = bch_params(DATA_BITS, T),
    localparam int unsigned M         = BCH_M(P),
    localparam int unsigned FRAME     = M + 1
)(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [M-1:0]          req_sigma,
    output logic                  busy,
    output logic                  ser_out,
    input  logic                  ser_in,
    input  logic                  sig_clear,
    output logic [MISR_WIDTH-1:0] sig,
    output logic [15:0]           frame_count
);

    localparam int unsigned CNT_W = $clog2(FRAME + 1);
    localparam int unsigned GAP_W = $clog2(GAP + 1);

    host_state_e      state_q, state_d;
    logic [FRAME-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [GAP_W-1:0] gapcnt_q, gapcnt_d;
    logic             ser_q, ser_d;
    logic [15:0]      fcnt_q, fcnt_d;

    assign req_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign ser_out     = ser_q;
    assign frame_count = fcnt_q;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        gapcnt_d = gapcnt_q;
        ser_d    = 1'b0;
        fcnt_d   = fcnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    // The first bit leaves on the accept edge, so the register
                    // holds the remainder of {sigma, start} left-aligned.
                    ser_d    = req_sigma[M-1];
                    shreg_d  = {req_sigma[M-2:0], 1'b1, 1'b0};
                    bitcnt_d = CNT_W'(1);
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bitcnt_q == CNT_W'(FRAME)) begin
                    gapcnt_d = '0;
                    state_d  = ST_GAP;
                end else begin
                    ser_d    = shreg_q[FRAME-1];
                    shreg_d  = shreg_q << 1;
                    bitcnt_d = bitcnt_q + CNT_W'(1);
                    if (bitcnt_q == CNT_W'(FRAME - 1)) begin
                        fcnt_d = fcnt_q + 16'd1;
                    end
                end
            end
            ST_GAP: begin
                if (gapcnt_q == GAP_W'(GAP - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gapcnt_d = gapcnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            gapcnt_q <= '0;
            ser_q    <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            gapcnt_q <= gapcnt_d;
            ser_q    <= ser_d;
            fcnt_q   <= fcnt_d;
        end
    end

    xilinx_serial_misr u_misr (
        .clk       (clk),
        .reset_n   (reset_n),
        .ser_in    (ser_in),
        .sig_clear (sig_clear),
        .sig       (sig)
    );

endmodule
`default_nettype wire

// File: tb/tb_xilinx_serial_host.sv
`default_nettype none
// ============================================================================
// Module  : tb_xilinx_serial_host
// Brief   : Directed self-checking bench for xilinx_serial_host (M=4, GAP=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_xilinx_serial_host;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_sigma;
    logic        busy;
    logic        ser_out;
    logic        ser_in;
    logic        sig_clear;
    logic [31:0] sig;
    logic [15:0] frame_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    xilinx_serial_host dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_sigma   (req_sigma),
        .busy        (busy),
        .ser_out     (ser_out),
        .ser_in      (ser_in),
        .sig_clear   (sig_clear),
        .sig         (sig),
        .frame_count (frame_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_sigma = 4'h0;
        ser_in    = 1'b0;
        sig_clear = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if ({req_ready, busy, ser_out} !== 3'b100) begin
            failures++;
            $display("FAIL reset_ctrl: got ready/busy/ser=%b required 100", {req_ready, busy, ser_out});
        end
        checks++;
        if (sig !== 32'h0) begin
            failures++;
            $display("FAIL reset_sig: got %h required 00000000", sig);
        end
        checks++;
        if (frame_count !== 16'h0) begin
            failures++;
            $display("FAIL reset_fcnt: got %0d required 0", frame_count);
        end
    endtask

    task automatic test_single_frame;
        int exp_s [1:10] = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 0};
        req_valid = 1'b1;
        req_sigma = 4'b1010;
        tick();
        req_valid = 1'b0;
        req_sigma = 4'b0101;
        for (int c = 1; c <= 10; c++) begin
            checks++;
            if (ser_out !== exp_s[c][0]) begin
                failures++;
                $display("FAIL single_ser c%0d: got %b required %0d", c, ser_out, exp_s[c]);
            end
            checks++;
            if (req_ready !== (c == 10) || busy !== (c != 10)) begin
                failures++;
                $display("FAIL single_hs c%0d: got ready=%b busy=%b required ready=%0d", c, req_ready, busy, (c == 10));
            end
            if (c == 4) begin
                checks++;
                if (frame_count !== 16'd0) begin
                    failures++;
                    $display("FAIL single_fcnt4: got %0d required 0", frame_count);
                end
            end
            if (c == 5 || c == 9) begin
                checks++;
                if (frame_count !== 16'd1) begin
                    failures++;
                    $display("FAIL single_fcnt c%0d: got %0d required 1", c, frame_count);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back;
        int exp_s [1:15] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
        req_valid = 1'b1;
        req_sigma = 4'hF;
        tick();
        req_sigma = 4'h3;
        for (int c = 1; c <= 15; c++) begin
            checks++;
            if (ser_out !== exp_s[c][0]) begin
                failures++;
                $display("FAIL b2b_ser c%0d: got %b required %0d", c, ser_out, exp_s[c]);
            end
            checks++;
            if (req_ready !== (c == 10)) begin
                failures++;
                $display("FAIL b2b_ready c%0d: got %b required %0d", c, req_ready, (c == 10));
            end
            if (c == 5) begin
                checks++;
                if (frame_count !== 16'd2) begin
                    failures++;
                    $display("FAIL b2b_fcnt5: got %0d required 2", frame_count);
                end
            end
            if (c == 15) begin
                checks++;
                if (frame_count !== 16'd3) begin
                    failures++;
                    $display("FAIL b2b_fcnt15: got %0d required 3", frame_count);
                end
            end
            if (c == 11) req_valid = 1'b0;
            tick();
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_idle: got ready=%b required 1", req_ready);
        end
    endtask

    task automatic test_misr;
        sig_clear = 1'b1;
        tick();
        sig_clear = 1'b0;
        ser_in    = 1'b1;
        tick();
        ser_in = 1'b0;
        tick();
        checks++;
        if (sig !== 32'h0) begin
            failures++;
            $display("FAIL misr_lat2: got %h required 00000000", sig);
        end
        tick();
        checks++;
        if (sig !== 32'h00000001) begin
            failures++;
            $display("FAIL misr_lat3: got %h required 00000001", sig);
        end
        for (int i = 0; i < 31; i++) tick();
        checks++;
        if (sig !== 32'h80000000) begin
            failures++;
            $display("FAIL misr_msb: got %h required 80000000", sig);
        end
        tick();
        checks++;
        if (sig !== 32'h04C11DB7) begin
            failures++;
            $display("FAIL misr_poly: got %h required 04c11db7", sig);
        end
    endtask

    task automatic test_sig_clear;
        sig_clear = 1'b1;
        tick();
        sig_clear = 1'b0;
        ser_in    = 1'b1;
        tick();
        ser_in = 1'b0;
        tick();
        sig_clear = 1'b1;
        tick();
        checks++;
        if (sig !== 32'h0) begin
            failures++;
            $display("FAIL clear_override: got %h required 00000000", sig);
        end
        sig_clear = 1'b0;
        tick();
        checks++;
        if (sig !== 32'h0) begin
            failures++;
            $display("FAIL clear_after: got %h required 00000000", sig);
        end
    endtask

    task automatic test_async_reset;
        int exp_s [1:5] = '{0, 1, 1, 0, 1};
        req_valid = 1'b1;
        req_sigma = 4'b1110;
        ser_in    = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (ser_out !== 1'b1 || busy !== 1'b1 || sig === 32'h0 || frame_count === 16'h0) begin
            failures++;
            $display("FAIL arst_pre: got ser=%b busy=%b sig=%h fcnt=%0d required ser=1 busy=1 nonzero sig/fcnt",
                     ser_out, busy, sig, frame_count);
        end
        reset_n = 1'b0;
        ser_in  = 1'b0;
        #1;
        checks++;
        if (ser_out !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL arst_ctrl: got ser=%b busy=%b ready=%b required 0 0 1", ser_out, busy, req_ready);
        end
        checks++;
        if (sig !== 32'h0 || frame_count !== 16'h0) begin
            failures++;
            $display("FAIL arst_regs: got sig=%h fcnt=%0d required 0 0", sig, frame_count);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (sig !== 32'h0) begin
            failures++;
            $display("FAIL arst_sync: got %h required 00000000", sig);
        end
        req_valid = 1'b1;
        req_sigma = 4'b0110;
        tick();
        req_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if (ser_out !== exp_s[c][0]) begin
                failures++;
                $display("FAIL arst_ser c%0d: got %b required %0d", c, ser_out, exp_s[c]);
            end
            tick();
        end
        checks++;
        if (frame_count !== 16'd1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL arst_fcnt: got fcnt=%0d busy=%b required 1 1", frame_count, busy);
        end
        for (int i = 0; i < 6; i++) tick();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_misr();
        test_sig_clear();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
